// File: rtl/chi_stage_pkg.sv
// Shared definitions for the permutation-round stages: state geometry,
// the common stage sequencing enum and the lane-index helper.
package chi_stage_pkg;

    localparam int WIDTH = 32'sd25;
    localparam int LINES = 32'sd64;
    localparam int CNT_W = 32'sd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } stage_state_e;

    // Bit position of lane (x, y) inside one 5x5 z-slice line.
    function automatic int idx(input int x, input int y);
        return (32'sd5 * y) + x;
    endfunction

endpackage

// File: rtl/chi_stage_if.sv
// Line-walk handshake between a round stage (slave) and the sequencer /
// slice memory side (master).
interface chi_stage_if;
    import chi_stage_pkg::*;

    logic             chi_en;
    logic             donee;
    logic [CNT_W-1:0] cnt_value;
    logic [WIDTH-1:0] line_in;
    logic             write_enable;
    logic [WIDTH-1:0] write_value;

    modport slave (
        input  chi_en,
        input  line_in,
        output donee,
        output cnt_value,
        output write_enable,
        output write_value
    );

    modport master (
        output chi_en,
        output line_in,
        input  donee,
        input  cnt_value,
        input  write_enable,
        input  write_value
    );

endinterface

// File: rtl/chi_stage_slice.sv
// Combinational chi over one 5x5 z-slice: each row of five lanes is
// transformed independently by the same nonlinear row function.
module chi_slice
    import chi_stage_pkg::*;
(
    input  logic [WIDTH-1:0] line_i,
    output logic [WIDTH-1:0] line_o
);

    function automatic logic [4:0] chi_row(input logic [4:0] r);
        logic [4:0] res;
        res = r;
        for (int x = 0; x < 32'sd5; x++) begin
            res[x] = r[x] ^ (~r[(x + 32'sd1) % 32'sd5] & r[(x + 32'sd2) % 32'sd5]);
        end
        return res;
    endfunction

    for (genvar y = 0; y < 5; y++) begin : g_row
        assign line_o[idx(0, y) +: 5] = chi_row(line_i[idx(0, y) +: 5]);
    end

endmodule

// File: rtl/chi_stage_top.sv
// Chi stage: walks every slice line of the state memory, reading a line in
// one cycle and writing its chi result back with a one-cycle strobe the next.
module chi_stage_top
    import chi_stage_pkg::*;
#(
    parameter int LINES = chi_stage_pkg::LINES,
    parameter int CNT_W = chi_stage_pkg::CNT_W,
    parameter int WIDTH = chi_stage_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    chi_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES - 32'sd1);

    if ((WIDTH != 32'sd25) || (LINES != (32'sd1 << CNT_W))
        || (CNT_W != chi_stage_pkg::CNT_W)) begin : g_bad_cfg
        $error("chi_stage_top: WIDTH must be 25 and LINES must equal 2**CNT_W");
    end

    stage_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wv_q, wv_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] chi_out;

    chi_slice u_chi (
        .line_i (bus.line_in),
        .line_o (chi_out)
    );

    // Next-state and next-output decode; outputs are registered so the
    // strobe and address change only on clock edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wv_d    = wv_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                wv_d  = '0;
                if (bus.chi_en) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                wv_d    = chi_out;
                we_d    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (cnt_q == LAST_LINE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                // Holding chi_en keeps the stage parked here; no restart.
                if (bus.chi_en) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    wv_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                wv_d    = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wv_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign bus.donee        = done_q;
    assign bus.cnt_value    = cnt_q;
    assign bus.write_enable = we_q;
    assign bus.write_value  = wv_q;

endmodule

// File: tb/tb_chi_stage_top.sv
// Self-checking bench for chi_stage_top: a behavioural slice memory plus a
// bit-level chi reference computed straight from the row equation.
module tb_chi_stage_top;
    import chi_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chi_stage_if bus ();

    logic [24:0] mem  [64];
    logic [24:0] snap [64];
    assign bus.line_in = mem[bus.cnt_value];

    chi_stage_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int nw;
    int first_done;
    int          wa [64];
    logic [24:0] wd [64];
    int          wc [64];

    function automatic logic [24:0] ref_chi(input logic [24:0] v);
        logic [24:0] r;
        int x, y;
        for (int i = 0; i < 25; i++) begin
            x = i % 5;
            y = i / 5;
            r[i] = v[i] ^ (~v[5 * y + (x + 1) % 5] & v[5 * y + (x + 2) % 5]);
        end
        return r;
    endfunction

    // Start a pass at edge 0 and record every write strobe with its cycle.
    task automatic run_pass(input bit hold);
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        nw = 0;
        first_done = -1;
        @(negedge clk);
        bus.chi_en = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 135; c++) begin
            @(negedge clk);
            if (!hold) bus.chi_en = 1'b0;
            if (bus.write_enable) begin
                if (nw < 64) begin
                    wa[nw] = int'(bus.cnt_value);
                    wd[nw] = bus.write_value;
                    wc[nw] = c;
                end
                nw++;
                mem[bus.cnt_value] = bus.write_value;
            end
            if (bus.donee && first_done < 0) first_done = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.chi_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.donee !== 1'b0 || bus.cnt_value !== 6'd0 || bus.write_enable !== 1'b0
            || bus.write_value !== 25'h0) begin
            errors++;
            $display("FAIL reset_state: got done=%b cnt=%0d we=%b wv=%h want 0/0/0/0",
                     bus.donee, bus.cnt_value, bus.write_enable, bus.write_value);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_hold();
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        run_pass(1'b1);
        checks++;
        if (nw != 64) begin errors++; $display("FAIL zero_pulses: got %0d want 64", nw); end
        for (int k = 0; k < 64 && k < nw; k++) begin
            checks++;
            if (wa[k] != k || wd[k] !== 25'h0 || wc[k] != 2 * k + 2) begin
                errors++;
                $display("FAIL zero_write%0d: got addr=%0d data=%h cyc=%0d want %0d/0/%0d",
                         k, wa[k], wd[k], wc[k], k, 2 * k + 2);
            end
        end
        checks++;
        if (first_done != 129) begin
            errors++; $display("FAIL zero_done_cycle: got %0d want 129", first_done);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.donee !== 1'b1 || bus.write_enable !== 1'b0 || bus.cnt_value !== 6'd63) begin
                errors++;
                $display("FAIL done_hold: got done=%b we=%b cnt=%0d want 1/0/63",
                         bus.donee, bus.write_enable, bus.cnt_value);
            end
        end
        bus.chi_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.donee !== 1'b0 || bus.cnt_value !== 6'd0 || bus.write_value !== 25'h0) begin
            errors++;
            $display("FAIL done_drop: got done=%b cnt=%0d wv=%h want 0/0/0",
                     bus.donee, bus.cnt_value, bus.write_value);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < 64; i++) mem[i] = 25'h1FFFFFF;
        run_pass(1'b0);
        checks++;
        if (nw != 64) begin errors++; $display("FAIL ones_pulses: got %0d want 64", nw); end
        for (int k = 0; k < 64 && k < nw; k++) begin
            checks++;
            if (wa[k] != k || wd[k] !== 25'h1FFFFFF) begin
                errors++;
                $display("FAIL ones_write%0d: got addr=%0d data=%h want %0d/1ffffff",
                         k, wa[k], wd[k], k);
            end
        end
        checks++;
        if (first_done != 129) begin
            errors++; $display("FAIL ones_done_cycle: got %0d want 129", first_done);
        end
    endtask

    task automatic test_line5();
        logic [24:0] exp;
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        mem[5] = 25'h0000004;
        run_pass(1'b0);
        checks++;
        if (nw != 64) begin errors++; $display("FAIL line5_pulses: got %0d want 64", nw); end
        for (int k = 0; k < 64 && k < nw; k++) begin
            exp = (k == 5) ? 25'h0000005 : 25'h0;
            checks++;
            if (wd[k] !== exp) begin
                errors++; $display("FAIL line5_write%0d: got %h want %h", k, wd[k], exp);
            end
        end
    endtask

    task automatic test_line63();
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        mem[63] = 25'h00000C0;
        run_pass(1'b0);
        checks++;
        if (nw != 64) begin
            errors++; $display("FAIL line63_pulses: got %0d want 64", nw);
        end else begin
            checks++;
            if (wd[63] !== 25'h00002C0 || wa[63] != 63 || wc[63] != 128) begin
                errors++;
                $display("FAIL line63_write: got data=%h addr=%0d cyc=%0d want 2c0/63/128",
                         wd[63], wa[63], wc[63]);
            end
            checks++;
            if (first_done != wc[63] + 1) begin
                errors++;
                $display("FAIL line63_done: got %0d want %0d", first_done, wc[63] + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 64; i++) mem[i] = 25'($urandom());
            run_pass(1'b0);
            checks++;
            if (nw != 64) begin errors++; $display("FAIL rand_pulses: got %0d want 64", nw); end
            for (int k = 0; k < 64 && k < nw; k++) begin
                checks++;
                if (wa[k] != k || wd[k] !== ref_chi(snap[k])) begin
                    errors++;
                    $display("FAIL rand_write%0d: got addr=%0d data=%h want %0d/%h",
                             k, wa[k], wd[k], k, ref_chi(snap[k]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 25'($urandom());
        @(negedge clk);
        bus.chi_en = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            bus.chi_en = 1'b0;
            if (bus.write_enable) begin
                mem[bus.cnt_value] = bus.write_value;
                if (bus.cnt_value == 6'd30) hit = 1'b1;
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midreset_reach: got no line30 write want one"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.donee !== 1'b0 || bus.cnt_value !== 6'd0 || bus.write_enable !== 1'b0
            || bus.write_value !== 25'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got done=%b cnt=%0d we=%b wv=%h want 0/0/0/0",
                     bus.donee, bus.cnt_value, bus.write_enable, bus.write_value);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.write_enable !== 1'b0 || bus.cnt_value !== 6'd0) begin
            errors++;
            $display("FAIL midreset_idle: got we=%b cnt=%0d want 0/0", bus.write_enable, bus.cnt_value);
        end
        run_pass(1'b0);
        checks++;
        if (nw != 64) begin errors++; $display("FAIL midreset_pulses: got %0d want 64", nw); end
        for (int k = 0; k < 64 && k < nw; k++) begin
            checks++;
            if (wa[k] != k || wd[k] !== ref_chi(snap[k])) begin
                errors++;
                $display("FAIL midreset_write%0d: got addr=%0d data=%h want %0d/%h",
                         k, wa[k], wd[k], k, ref_chi(snap[k]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int extra;
        for (int i = 0; i < 64; i++) mem[i] = 25'($urandom());
        run_pass(1'b1);
        checks++;
        if (nw != 64) begin errors++; $display("FAIL b2b_first_pulses: got %0d want 64", nw); end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.write_enable) extra++;
        end
        checks++;
        if (extra != 0 || bus.donee !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_restart: got writes=%0d done=%b want 0/1", extra, bus.donee);
        end
        bus.chi_en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.donee !== 1'b0) begin
            errors++; $display("FAIL b2b_drop: got done=%b want 0", bus.donee);
        end
        run_pass(1'b0);
        checks++;
        if (nw != 64) begin errors++; $display("FAIL b2b_second_pulses: got %0d want 64", nw); end
        for (int k = 0; k < 64 && k < nw; k++) begin
            checks++;
            if (wa[k] != k || wd[k] !== ref_chi(snap[k]) || wc[k] != 2 * k + 2) begin
                errors++;
                $display("FAIL b2b_write%0d: got addr=%0d data=%h cyc=%0d want %0d/%h/%0d",
                         k, wa[k], wd[k], wc[k], k, ref_chi(snap[k]), 2 * k + 2);
            end
        end
    endtask

    initial begin
        bus.chi_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 25'h0;
        test_reset();
        test_zero_hold();
        test_ones();
        test_line5();
        test_line63();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
